// File: rtl/mma_icb_pkg.sv
// rtl/mma_icb_pkg.sv - shared requester IDs, ID type and ICB size encodings for the MMA ICB arbiter
package mma_icb_pkg;

  localparam int MMA_NUM_REQ = 4;

  localparam int REQ_WB   = 0;
  localparam int REQ_WGT  = 1;
  localparam int REQ_BIAS = 2;
  localparam int REQ_IA   = 3;

  typedef logic [$clog2(MMA_NUM_REQ)-1:0] req_id_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/icb_id_fifo.sv
// rtl/icb_id_fifo.sv - circular buffer of requester IDs for commands awaiting their response
module icb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic                   pop,
  output logic [ID_W-1:0]        head_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_id = mem_q[rd_q];
  assign count   = cnt_q;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/mma_icb_arbiter.sv
// rtl/mma_icb_arbiter.sv - round-robin ICB command arbiter with grant lock and in-order response routing
// Define MMA_ICB_ARB_WB_PRIO_EN to give the write-back requester strict priority whenever no grant is locked.
module mma_icb_arbiter
  import mma_icb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_cmd_valid,
  output logic [NUM_REQ-1:0]            req_cmd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_cmd_addr,
  input  logic [NUM_REQ-1:0]            req_cmd_read,
  input  logic [NUM_REQ*DATA_W-1:0]     req_cmd_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_cmd_wmask,
  input  logic [NUM_REQ*2-1:0]          req_cmd_size,
  output logic [NUM_REQ-1:0]            req_rsp_valid,
  input  logic [NUM_REQ-1:0]            req_rsp_ready,
  output logic [DATA_W-1:0]             req_rsp_rdata,
  output logic                          req_rsp_err,
  output logic                          sa_icb_cmd_valid,
  input  logic                          sa_icb_cmd_ready,
  output logic [ADDR_W-1:0]             sa_icb_cmd_addr,
  output logic                          sa_icb_cmd_read,
  output logic [DATA_W-1:0]             sa_icb_cmd_wdata,
  output logic [DATA_W/8-1:0]           sa_icb_cmd_wmask,
  output logic [1:0]                    sa_icb_cmd_size,
  input  logic                          sa_icb_rsp_valid,
  output logic                          sa_icb_rsp_ready,
  input  logic [DATA_W-1:0]             sa_icb_rsp_rdata,
  input  logic                          sa_icb_rsp_err,
  output logic                          arb_idle,
  output logic                          arb_err
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(OUTS_DEPTH) + 1;

  typedef logic [ID_W-1:0] id_t;

  logic             lock_q, lock_d;
  id_t              grant_q, grant_d;
  id_t              rr_ptr_q, rr_ptr_d;
  logic             arb_err_q, arb_err_d;
  id_t              scan_id, sel_id, head_id;
  logic             scan_found, sel_valid, not_full, cmd_hs, rsp_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  function automatic id_t wrap_inc(input id_t id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + id_t'(1);
  endfunction

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    id_t cand;
    scan_found = 1'b0;
    scan_id    = rr_ptr_q;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k >= NUM_REQ) ? id_t'(int'(rr_ptr_q) + k - NUM_REQ)
                                             : id_t'(int'(rr_ptr_q) + k);
      if (req_cmd_valid[cand]) begin
        scan_found = 1'b1;
        scan_id    = cand;
      end
    end
  end

  always_comb begin
    sel_id    = lock_q ? grant_q : scan_id;
    sel_valid = lock_q ? req_cmd_valid[grant_q] : scan_found;
`ifdef MMA_ICB_ARB_WB_PRIO_EN
    if (!lock_q && req_cmd_valid[REQ_WB]) begin
      sel_id    = id_t'(REQ_WB);
      sel_valid = 1'b1;
    end
`endif
  end

  assign not_full = ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      arb_err_q <= arb_err_d;
    end
  end

  // A full ID queue blocks issue, so nothing below moves while it is full.
  always_comb begin
    lock_d   = lock_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (cmd_hs) begin
      lock_d   = 1'b0;
      grant_d  = sel_id;
      rr_ptr_d = wrap_inc(sel_id);
    end else if (lock_q && !req_cmd_valid[grant_q]) begin
      lock_d = 1'b0;
    end else if (!lock_q && sel_valid && not_full) begin
      lock_d  = 1'b1;
      grant_d = sel_id;
    end
  end

  always_comb begin
    sa_icb_cmd_valid       = sel_valid & not_full;
    sa_icb_cmd_addr        = req_cmd_addr[int'(sel_id)*ADDR_W +: ADDR_W];
    sa_icb_cmd_read        = req_cmd_read[sel_id];
    sa_icb_cmd_wdata       = req_cmd_wdata[int'(sel_id)*DATA_W +: DATA_W];
    sa_icb_cmd_wmask       = req_cmd_wmask[int'(sel_id)*MASK_W +: MASK_W];
    sa_icb_cmd_size        = req_cmd_size[int'(sel_id)*2 +: 2];
    cmd_hs                 = sa_icb_cmd_valid & sa_icb_cmd_ready;
    req_cmd_ready          = '0;
    req_cmd_ready[sel_id]  = cmd_hs;
  end

  // A response with nothing outstanding is accepted and dropped so the bus cannot wedge.
  always_comb begin
    req_rsp_valid    = '0;
    sa_icb_rsp_ready = fifo_empty ? sa_icb_rsp_valid : req_rsp_ready[head_id];
    if (!fifo_empty) begin
      req_rsp_valid[head_id] = sa_icb_rsp_valid;
    end
    rsp_pop   = sa_icb_rsp_valid & ~fifo_empty & req_rsp_ready[head_id];
    arb_err_d = arb_err_q | (sa_icb_rsp_valid & fifo_empty);
  end

  assign req_rsp_rdata = sa_icb_rsp_rdata;
  assign req_rsp_err   = sa_icb_rsp_err;
  assign arb_idle      = ~lock_q & (fifo_count == '0) & ~|req_cmd_valid;
  assign arb_err       = arb_err_q;

  icb_id_fifo #(
    .DEPTH (OUTS_DEPTH),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_hs),
    .push_id (sel_id),
    .pop     (rsp_pop),
    .head_id (head_id),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/mma_icb_arbiter.md
Name: mma_icb_arbiter

Overview:
- Shares the single MMA memory ICB port between NUM_REQ internal requesters:
  - requester 0 = output write-back (FIFO drain)
  - requester 1 = weight fetch
  - requester 2 = bias / quant-param fetch
  - requester 3 = IA fetch
- Sits between the MMA controller's fetch/store engines and the LSU-facing sa_icb_* port.
- Round-robin command arbitration with grant lock.
- In-order response routing via an outstanding-ID queue.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, ICB address width
- DATA_W, 32, ICB data width
- OUTS_DEPTH, 4, maximum outstanding commands (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- req_cmd_valid  in  NUM_REQ  per-requester command valid
- req_cmd_ready  out  NUM_REQ  per-requester command ready
- req_cmd_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_cmd_read  in  NUM_REQ  1 = read
- req_cmd_wdata  in  NUM_REQ*DATA_W  packed write data
- req_cmd_wmask  in  NUM_REQ*(DATA_W/8)  packed byte masks
- req_cmd_size  in  NUM_REQ*2  packed sizes
- req_rsp_valid  out  NUM_REQ  routed response valid
- req_rsp_ready  in  NUM_REQ  per-requester response ready
- req_rsp_rdata  out  DATA_W  shared read data, qualified by req_rsp_valid
- req_rsp_err  out  1  shared error, qualified by req_rsp_valid
- sa_icb_cmd_valid/ready/addr/read/wdata/wmask/size  out/in/out/out/out/out/out  1/1/ADDR_W/1/DATA_W/DATA_W/8/2  master command channel
- sa_icb_rsp_valid/ready/rdata/err  in/out/in/in  1/1/DATA_W/1  master response channel
- arb_idle  out  1  no lock held and no commands outstanding
- arb_err  out  1  sticky: response arrived with empty ID queue

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - rr_ptr=0, lock=0, grant_id=0
  - ID queue empty, count=0, arb_err=0
- Resulting outputs during reset: all valids/readies low, arb_idle=1.
- Command path is combinational: zero latency from the granted requester to sa_icb_cmd_*.
- Arbiter states:
  - IDLE: pick the first valid requester scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … NUM_REQ-1, 0 …). If chosen and not accepted this cycle → LOCKED with grant_id registered.
  - LOCKED: grant stays on grant_id until handshake; no re-arbitration even if a higher-rank requester asserts. This preserves ICB valid/payload stability.
  - On handshake (sa_icb_cmd_valid & sa_icb_cmd_ready): rr_ptr←grant+1 (mod NUM_REQ), lock←0, push grant id.
- sa_icb_cmd_valid = selected req_cmd_valid & (count<OUTS_DEPTH).
- req_cmd_ready[i] = (i==grant) & sa_icb_cmd_ready & (count<OUTS_DEPTH); 0 for all others.
- Queue full (count==OUTS_DEPTH):
  - no command issued
  - grant/lock state frozen
  - requesters are not starved of fairness because rr_ptr is unchanged
- Response routing:
  - head = queue head id
  - req_rsp_valid[head] = sa_icb_rsp_valid & count≠0
  - sa_icb_rsp_ready = req_rsp_ready[head]
  - rdata/err forwarded unchanged
  - pop on rsp handshake
- Response with count==0:
  - sa_icb_rsp_ready=1, response dropped
  - arb_err←1 (cleared only by reset)
- Simultaneous push and pop in one cycle: count unchanged, head advances, tail advances. Push into a full queue with a same-cycle pop is not allowed: issue is gated on the registered count.
- A requester deasserting valid while locked (protocol violation): lock released next cycle, no command issued.
- arb_idle = ~lock & (count==0) & ~|req_cmd_valid.

Optional Feature:
- Macro: MMA_ICB_ARB_WB_PRIO_EN.
- Defined: requester 0 (write-back) has strict priority in IDLE whenever req_cmd_valid[0]=1, ahead of the round-robin scan. An existing LOCKED grant is still honoured. Purpose: keep the output FIFO from stalling the requant pipeline.
- Undefined: pure round robin for all requesters.

Decomposition:
- Package mma_icb_pkg:
  - requester ID constants REQ_WB=0, REQ_WGT=1, REQ_BIAS=2, REQ_IA=3
  - typedef req_id_t = logic [$clog2(NUM_REQ)-1:0]
  - ICB size encodings SIZE_B=0, SIZE_H=1, SIZE_W=2
- Sub-module icb_id_fifo: OUTS_DEPTH × req_id_t circular buffer providing push/pop/head/count/full/empty.
- Arbitration and mux stay in the top.

Test Plan:
- Single requester: req1 reads 0x1000; cmd_ready=1 → sa_icb_cmd_addr=0x1000 same cycle. rsp rdata=0xDEADBEEF → req_rsp_valid=4'b0010, rdata=0xDEADBEEF.
- Round robin: all 4 requesters valid, cmd_ready always 1 → grant order 0,1,2,3,0. Responses return in order and route to 0,1,2,3.
- Lock: req2 granted, cmd_ready held 0 for 3 cycles while req0 asserts → addr/data stay req2's; req0 granted on the cycle after the handshake.
- Outstanding limit: 4 commands issued, no responses → 5th request sees req_cmd_ready=0 and sa_icb_cmd_valid=0. One response popped → issue resumes the next cycle.
- Stray response: sa_icb_rsp_valid with count=0 → sa_icb_rsp_ready=1, arb_err=1 sticky; rst_n low mid-burst → arb_err=0, count=0, arb_idle=1.
- With MMA_ICB_ARB_WB_PRIO_EN: rr_ptr=2 with req0 and req3 valid → req0 granted. Without the macro → req3 granted.
